// File: rtl/hex_display_sequencer.sv
// hex_display_sequencer: Avalon-MM write master that shows a packed nibble word on HEX PIO slaves; define HEX_LEADING_BLANK_EN to blank leading zero digits
module hex_display_sequencer #(
  parameter int NUM_DIGITS = 8,
  parameter int WRITE_GAP  = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [4*NUM_DIGITS-1:0] req_value,
  output logic                    done,
  output logic                    busy,
  output logic [NUM_DIGITS-1:0]   hex_chipselect,
  output logic                    hex_write_n,
  output logic [1:0]              hex_address,
  output logic [31:0]             hex_writedata
);
  localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  typedef enum logic [1:0] {IDLE, WRITE, GAP, DONE} state_t;
  state_t                state_q, state_d;
  logic [DW-1:0]         digit_q, digit_d;
  logic [3:0]            gap_q, gap_d;
  logic [6:0]            shadow_q [NUM_DIGITS];
  logic [6:0]            shadow_d [NUM_DIGITS];
  logic [6:0]            enc [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] cs_q, cs_d;
  logic                  wn_q, wn_d, done_q, done_d, busy_q, busy_d, ready_q, ready_d;
  logic [6:0]            seg_q, seg_d;

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  endfunction

  // Segment patterns for every digit of the incoming request, captured at accept
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) enc[i] = seg(req_value[4*i +: 4]);
`ifdef HEX_LEADING_BLANK_EN
    for (int i = 1; i < NUM_DIGITS; i++) if ((req_value >> (4*i)) == '0) enc[i] = 7'h7F;
`endif
  end

  // Sequencing of digit writes and gaps, plus the registered bus/status outputs
  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    gap_d    = gap_q;
    shadow_d = shadow_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d  = WRITE;
        digit_d  = '0;
        shadow_d = enc;
      end
      WRITE: if (digit_q == DW'(NUM_DIGITS - 1)) state_d = DONE;
        else if (WRITE_GAP > 0) begin
          state_d = GAP;
          gap_d   = 4'(WRITE_GAP - 1);
        end else digit_d = digit_q + DW'(1);
      GAP: if (gap_q == '0) begin
          state_d = WRITE;
          digit_d = digit_q + DW'(1);
        end else gap_d = gap_q - 4'd1;
      default: state_d = IDLE;
    endcase
    cs_d    = state_d == WRITE ? NUM_DIGITS'(1) << digit_d : '0;
    wn_d    = state_d != WRITE;
    done_d  = state_d == DONE;
    busy_d  = state_d != IDLE;
    ready_d = state_d == IDLE;
    seg_d   = state_d == WRITE ? shadow_d[digit_d] : seg_q;
  end

  // State and output registers; reset abandons any sequence in progress
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      digit_q  <= '0;
      gap_q    <= '0;
      shadow_q <= '{default: 7'h0};
      cs_q     <= '0;
      wn_q     <= 1'b1;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      seg_q    <= '0;
    end else begin
      state_q  <= state_d;
      digit_q  <= digit_d;
      gap_q    <= gap_d;
      shadow_q <= shadow_d;
      cs_q     <= cs_d;
      wn_q     <= wn_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      seg_q    <= seg_d;
    end
  end

  assign req_ready      = ready_q;
  assign done           = done_q;
  assign busy           = busy_q;
  assign hex_chipselect = cs_q;
  assign hex_write_n    = wn_q;
  assign hex_address    = 2'b0;
  assign hex_writedata  = {25'b0, seg_q};
endmodule

// File: tb/tb_hex_display_sequencer.sv
// tb_hex_display_sequencer: directed bench with a timing/glyph model for two sequencer configurations
module tb_hex_display_sequencer;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        va = 1'b0, vb = 1'b0;
  logic [31:0] vala = '0;
  logic [15:0] valb = '0;
  logic        ra, da, ba, wna, rb, db, bb, wnb;
  logic [7:0]  csa;
  logic [3:0]  csb;
  logic [1:0]  ada, adb;
  logic [31:0] wda, wdb;
  int passed = 0, total = 0;

  hex_display_sequencer #(.NUM_DIGITS(8), .WRITE_GAP(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .req_valid(va), .req_ready(ra), .req_value(vala),
    .done(da), .busy(ba), .hex_chipselect(csa), .hex_write_n(wna),
    .hex_address(ada), .hex_writedata(wda));

  hex_display_sequencer #(.NUM_DIGITS(4), .WRITE_GAP(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .req_valid(vb), .req_ready(rb), .req_value(valb),
    .done(db), .busy(bb), .hex_chipselect(csb), .hex_write_n(wnb),
    .hex_address(adb), .hex_writedata(wdb));

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0] t1 [8] = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h30, 7'h24, 7'h79, 7'h40};
  logic [6:0] t2 [4] = '{7'h12, 7'h40, 7'h0E, 7'h00};
`ifdef HEX_LEADING_BLANK_EN
  logic [6:0] lead = 7'h7F;
`else
  logic [6:0] lead = 7'h40;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [6:0] glyph(input logic [31:0] v, input int d);
    logic [31:0] up;
    up = v >> (4*d);
`ifdef HEX_LEADING_BLANK_EN
    if (d > 0 && up == 0) return 7'h7F;
`endif
    return seg_tab[up[3:0]];
  endfunction

  int         nd [2] = '{8, 4};
  int         gp [2] = '{0, 2};
  bit         act [2];
  int         k [2];
  logic [31:0] mv [2];
  logic [6:0] last [2] = '{7'h0, 7'h0};

  // Model: a request occupies cycles 1..P with a write every (gap+1) cycles, done at P+1, ready again at P+2
  always @(posedge clk) begin
    int p, dig;
    bit wr;
    logic [45:0] e, a;
    for (int d = 0; d < 2; d++) begin
      p = nd[d] * (1 + gp[d]) - gp[d];
      if (!reset_n) begin
        act[d] = 1'b0;
        last[d] = 7'h0;
      end else if (!act[d]) begin
        if (d == 0 ? va : vb) begin
          act[d] = 1'b1;
          k[d] = 1;
          mv[d] = d == 0 ? vala : {16'h0, valb};
        end
      end else begin
        k[d]++;
        if (k[d] == p + 2) act[d] = 1'b0;
      end
      if (act[d] && k[d] <= p && (k[d] - 1) % (gp[d] + 1) == 0)
        last[d] = glyph(mv[d], (k[d] - 1) / (gp[d] + 1));
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      p = nd[d] * (1 + gp[d]) - gp[d];
      wr = act[d] && k[d] <= p && (k[d] - 1) % (gp[d] + 1) == 0;
      dig = (k[d] - 1) / (gp[d] + 1);
      e = {!act[d], act[d], act[d] && k[d] == p + 1, !wr, wr ? 8'(1) << dig : 8'h0, 2'b0, 25'b0, last[d]};
      a = d == 0 ? {ra, ba, da, wna, csa, ada, wda} : {rb, bb, db, wnb, 4'h0, csb, adb, wdb};
      chk(d == 0 ? "model_a" : "model_b", 64'(a), 64'(e));
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 chk("reset_idle", {ra, ba, da, wna, csa, wda}, {1'b1, 1'b0, 1'b0, 1'b1, 8'h0, 32'h0});
    @(negedge clk);
    va = 1'b1; vala = 32'h0123ABCD;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      va = 1'b0;
      if (c <= 8) chk("t1_write", {csa, wna, wda[6:0]}, {8'(1) << (c - 1), 1'b0, t1[c-1]});
      if (c == 9) chk("t1_done", {da, ra}, 2'b10);
      if (c == 10) chk("t1_ready", {da, ra, ba}, 3'b010);
    end
    vb = 1'b1; valb = 16'h8F05;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      vb = 1'b0;
      if (c <= 10 && (c - 1) % 3 == 0)
        chk("t2_write", {csb, wnb, wdb[6:0]}, {4'(1) << ((c - 1) / 3), 1'b0, t2[(c-1)/3]});
      else if (c <= 10) chk("t2_gap", {csb, wnb}, 5'b00001);
      if (c == 11) chk("t2_done", {db, rb}, 2'b10);
      if (c == 12) chk("t2_ready", {db, rb}, 2'b01);
    end
    va = 1'b1; vala = 32'h11111111;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("t3_first_value", wda[6:0], 7'h79);
        vala = 32'h22222222;
      end
      if (c == 9) chk("t3_no_early_ready", ra, 1'b0);
      if (c == 10) chk("t3_reaccept_ready", ra, 1'b1);
      if (c == 11) begin
        chk("t3_second_value", {csa, wna, ra, wda[6:0]}, {8'h01, 1'b0, 1'b0, 7'h24});
        va = 1'b0;
      end
    end
    repeat (10) @(negedge clk);
    va = 1'b1; vala = 32'h76543210;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      va = 1'b0;
      if (c == 3) chk("t4_third_write", {csa, wda[6:0]}, {8'h04, 7'h24});
    end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk("t4_reset_now", {csa, wna, ba, ra, da}, {8'h0, 1'b1, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    va = 1'b1; vala = 32'h89ABCDEF;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      va = 1'b0;
      if (c == 1) chk("t4_restart", {csa, wda[6:0]}, {8'h01, 7'h0E});
      if (c == 9) chk("t4_done", da, 1'b1);
    end
    va = 1'b1; vala = 32'h00000A07;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      va = 1'b0;
      if (c == 1) chk("t5_d0", wda[6:0], 7'h78);
      if (c == 2) chk("t5_d1", wda[6:0], 7'h40);
      if (c == 3) chk("t5_d2", wda[6:0], 7'h08);
      if (c == 4) chk("t5_d3", wda[6:0], lead);
      if (c == 8) chk("t5_d7", wda[6:0], lead);
    end
    va = 1'b1; vala = 32'h0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      va = 1'b0;
      if (c == 1) chk("t6_zero_d0", wda[6:0], 7'h40);
      if (c == 2) chk("t6_zero_d1", wda[6:0], lead);
      if (c == 8) chk("t6_zero_d7", {csa, wda[6:0]}, {8'h80, lead});
    end
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
